// File: rtl/seq_normalizer_if.sv
// rtl/seq_normalizer_if.sv - request/result bundle between a requester and seq_normalizer
//
// Purpose: groups the start/operand signals and the busy/done/result signals of
// the iterative normalizer so that they travel as a single port.
// Signals:
//   start     requester -> normalizer  request, sampled only while idle
//   data_in   requester -> normalizer  word to normalize
//   lr        requester -> normalizer  1 = normalize toward MSB, 0 = toward LSB
//   busy      normalizer -> requester  high while shifting
//   done      normalizer -> requester  one-cycle result-valid pulse
//   data_out  normalizer -> requester  normalized word
//   n         normalizer -> requester  number of positions shifted
//   zero      normalizer -> requester  captured word was zero
interface seq_normalizer_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             lr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic [CNTW-1:0]  n;
  logic             zero;

  modport master (
    output start, data_in, lr,
    input  busy, done, data_out, n, zero
  );

  modport slave (
    input  start, data_in, lr,
    output busy, done, data_out, n, zero
  );
endinterface

// File: rtl/seq_normalizer.sv
// rtl/seq_normalizer.sv - iterative one-bit-per-clock normalizer, inverse of barrel_shifter
//
// Purpose: shifts a captured word one position per clock toward the target end
// (MSB when lr=1, LSB when lr=0) until the target bit is 1, then reports the
// normalized word and the shift distance. Shifting the result back by n in the
// opposite direction reproduces the original word, since only zeros leave.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset
//   io_bus  seq_normalizer_if slave modport (start/data_in/lr in,
//           busy/done/data_out/n/zero out); all outputs come from registers
module seq_normalizer #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  seq_normalizer_if.slave  io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_word;
  logic [CNTW-1:0]  r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_out;
  logic [CNTW-1:0]  r_n;
  logic             r_zero;

  logic             w_is_zero;
  logic             w_target;
  logic [WIDTH-1:0] w_shifted;

  // Next-state and datapath decode
  always_comb begin
    w_next_state = r_state;
    w_is_zero    = (r_word == '0);
    w_target     = r_dir ? r_word[WIDTH-1] : r_word[0];
    w_shifted    = r_dir ? {r_word[WIDTH-2:0], 1'b0} : {1'b0, r_word[WIDTH-1:1]};
    case (r_state)
      S_IDLE:  if (io_bus.start) w_next_state = S_SHIFT;
      // A zero word or a set target bit both finish; neither case shifts again
      S_SHIFT: if (w_is_zero || w_target) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: results only move on the SHIFT->DONE edge and hold otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_out  <= '0;
      r_n    <= '0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_word <= io_bus.data_in;
            r_dir  <= io_bus.lr;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          if (w_is_zero) begin
            r_zero <= 1'b1;
            r_out  <= '0;
            r_n    <= '0;
          end else if (w_target) begin
            r_zero <= 1'b0;
            r_out  <= r_word;
            r_n    <= r_cnt;
          end else begin
            // A nonzero word hits its target within WIDTH-1 shifts, so r_cnt cannot wrap
            r_word <= w_shifted;
            r_cnt  <= r_cnt + CNTW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.busy     = (r_state == S_SHIFT);
  assign io_bus.done     = (r_state == S_DONE);
  assign io_bus.data_out = r_out;
  assign io_bus.n        = r_n;
  assign io_bus.zero     = r_zero;

endmodule
